// File: rtl/countdown_timer.sv
// countdown_timer: four-digit BCD mm:ss countdown timer.
//   A start time is loaded, then the timer is started and paused. One second is
//   counted down for every DIV clocks, with borrows rippling through the digits.
//   Reaching 00:00 gives a one-cycle done pulse and parks the timer in EXPIRED.
// Ports:
//   clk, reset_n                 clock; synchronous active-low reset
//   load, ld_min_t..ld_sec_o     load a start time (clamped to legal BCD); goes to IDLE
//   start_resume, stop           start from IDLE / resume from PAUSE; pause while running
//   min_t, min_o, sec_t, sec_o   current digits (registered)
//   running, expired             state decodes (RUN, EXPIRED)
//   done                         one-cycle pulse on reaching 00:00
module countdown_timer #(
  parameter int DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [3:0] ld_min_t,
  input  logic [3:0] ld_min_o,
  input  logic [3:0] ld_sec_t,
  input  logic [3:0] ld_sec_o,
  input  logic       start_resume,
  input  logic       stop,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } digits_t;

  state_t          state;
  digits_t         cur, dec, ld_val;
  logic [PW-1:0]   presc;
  logic            cur_zero, dec_zero;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Clamp the load digits so the counter never holds an illegal BCD value.
  always_comb begin
    ld_val.min_t = clamp(ld_min_t, 4'd9);
    ld_val.min_o = clamp(ld_min_o, 4'd9);
    ld_val.sec_t = clamp(ld_sec_t, 4'd5);
    ld_val.sec_o = clamp(ld_sec_o, 4'd9);
  end

  // One-second decrement with borrow chain. Only applied when cur != 00:00,
  // so min_t never underflows.
  always_comb begin
    dec = cur;
    if (cur.sec_o != 4'd0) begin
      dec.sec_o = cur.sec_o - 4'd1;
    end else begin
      dec.sec_o = 4'd9;
      if (cur.sec_t != 4'd0) begin
        dec.sec_t = cur.sec_t - 4'd1;
      end else begin
        dec.sec_t = 4'd5;
        if (cur.min_o != 4'd0) begin
          dec.min_o = cur.min_o - 4'd1;
        end else begin
          dec.min_o = 4'd9;
          dec.min_t = cur.min_t - 4'd1;
        end
      end
    end
  end

  assign cur_zero = (cur == '0);
  assign dec_zero = (dec == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur   <= '0;
      presc <= '0;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cur   <= ld_val;
        presc <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_resume) begin
              if (cur_zero) begin
                state <= EXPIRED;
                done  <= 1'b1;
              end else begin
                state <= RUN;
                presc <= '0;
              end
            end
          end
          RUN: begin
            // stop beats a coincident tick: the prescaler stays at LAST so
            // the pending tick fires on the first RUN edge after resume.
            if (stop) begin
              state <= PAUSE;
            end else if (presc == LAST) begin
              presc <= '0;
              cur   <= dec;
              if (dec_zero) begin
                state <= EXPIRED;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSE: begin
            if (start_resume && !stop) state <= RUN;
          end
          EXPIRED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign min_t   = cur.min_t;
  assign min_o   = cur.min_o;
  assign sec_t   = cur.sec_t;
  assign sec_o   = cur.sec_o;
  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer (DIV=4).
//   Each cycle the stimulus and the expected post-edge outputs are pushed
//   together; after the edge the expectation is popped and compared.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset_n, load, start_resume, stop;
  logic [3:0] ld_min_t, ld_min_o, ld_sec_t, ld_sec_o;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       running, done, expired;

  always #5 clk = ~clk;

  countdown_timer #(.DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .load(load),
    .ld_min_t(ld_min_t), .ld_min_o(ld_min_o), .ld_sec_t(ld_sec_t), .ld_sec_o(ld_sec_o),
    .start_resume(start_resume), .stop(stop),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .done(done), .expired(expired)
  );

  typedef struct packed {
    logic [15:0] dig;
    logic        run;
    logic        dn;
    logic        exp;
  } obs_t;

  obs_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   step = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  function automatic obs_t e(input logic [15:0] d, input logic r, input logic dn, input logic ex);
    obs_t o;
    o.dig = d; o.run = r; o.dn = dn; o.exp = ex;
    return o;
  endfunction

  // One clock: drive inputs, push expectation, clock, pop and compare.
  task automatic cyc(input logic rn, input logic ld, input logic [15:0] ldv,
                     input logic sr, input logic sp, input obs_t x);
    obs_t got;
    reset_n      = rn;
    load         = ld;
    {ld_min_t, ld_min_o, ld_sec_t, ld_sec_o} = ldv;
    start_resume = sr;
    stop         = sp;
    sb.push_back(x);
    @(posedge clk);
    #1;
    step++;
    got = sb.pop_front();
    chk("digits",  {16'd0, min_t, min_o, sec_t, sec_o}, {16'd0, got.dig});
    chk("running", {31'd0, running}, {31'd0, got.run});
    chk("done",    {31'd0, done},    {31'd0, got.dn});
    chk("expired", {31'd0, expired}, {31'd0, got.exp});
  endtask

  task automatic idle_n(input int n, input obs_t x);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, x);
  endtask

  initial begin
    // 1. reset, then reset again from the middle of a run
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0000, 0, 0, 0));
    cyc(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, e(16'h1234, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h1234, 1, 0, 0));
    idle_n(2, e(16'h1234, 1, 0, 0));
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0000, 0, 0, 0));

    // 2. full borrow chain 01:00 -> 00:59
    cyc(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, e(16'h0100, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0100, 1, 0, 0));
    idle_n(3, e(16'h0100, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0059, 1, 0, 0));

    // 3. 00:02 down to expiry, then EXPIRED ignores start_resume
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 1'b0, e(16'h0002, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0002, 1, 0, 0));
    idle_n(3, e(16'h0002, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0001, 1, 0, 0));
    idle_n(3, e(16'h0001, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0000, 0, 1, 1));
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b0, 16'h0, logic'(i % 2), logic'(i % 3 == 0), e(16'h0000, 0, 0, 1));

    // 4. pause/resume keeps prescaler; tick+stop defers the tick
    cyc(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, e(16'h0010, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0010, 1, 0, 0));
    idle_n(2, e(16'h0010, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, e(16'h0010, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 1'b0, 16'h0, 1'b0, logic'(i % 2), e(16'h0010, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0010, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0010, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0009, 1, 0, 0));
    idle_n(3, e(16'h0009, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, e(16'h0009, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0009, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0008, 1, 0, 0));

    // 5. clamping, load during RUN, stop+start_resume together
    cyc(1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0, e(16'h9959, 0, 0, 0));
    cyc(1'b1, 1'b1, 16'h0A6A, 1'b0, 1'b0, e(16'h0959, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0959, 1, 0, 0));
    cyc(1'b1, 1'b1, 16'h0500, 1'b1, 1'b1, e(16'h0500, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0500, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, e(16'h0500, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, e(16'h0500, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0500, 1, 0, 0));
    idle_n(3, e(16'h0500, 1, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0459, 1, 0, 0));

    // 6. start from 00:00 expires at once; load leaves EXPIRED
    cyc(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, e(16'h0000, 0, 0, 0));
    cyc(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, e(16'h0000, 0, 1, 1));
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, e(16'h0000, 0, 0, 1));
    cyc(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, e(16'h0005, 0, 0, 0));
    idle_n(2, e(16'h0005, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
